// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
//   One requester's connection to the ALU arbiter: a valid/ready request
//   channel carrying two operands and an opcode, and a valid/ready response
//   channel. The response data itself (result and flags) is shared by all
//   requesters and lives on the arbiter's plain ports.
//
//   master : the requester (drives the request, accepts the response)
//   slave  : the arbiter   (accepts the request, presents the response)
// ---------------------------------------------------------------------------
interface alu_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_aluc;
    logic        rsp_valid;
    logic        rsp_ready;

    modport master (
        output req_valid, req_a, req_b, req_aluc, rsp_ready,
        input  req_ready, rsp_valid
    );

    modport slave (
        input  req_valid, req_a, req_b, req_aluc, rsp_ready,
        output req_ready, rsp_valid
    );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one 32-bit ALU between requester 0 (core datapath) and requester 1
//   (address/branch unit). A granted request's operands and opcode are
//   registered onto the ALU, held for EXEC_CYCLES cycles, and then the ALU
//   result and flags are captured and offered back to the owner. Ties are
//   broken round-robin against the requester that completed last.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req0, req1          requester channels (alu_arbiter_if.slave)
//   rsp_r, rsp_flags    captured result / {zero, carry, negative, overflow},
//                       qualified by the owner's rsp_valid
//   alu_a/b/aluc        registered operands and opcode to the ALU
//   alu_r, alu_*flags   ALU result and flags
//   busy                high whenever an operation is in flight
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_arbiter_if.slave        req0,
    alu_arbiter_if.slave        req1,
    output logic [31:0]         rsp_r,
    output logic [3:0]          rsp_flags,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic [3:0]          alu_aluc,
    input  logic [31:0]         alu_r,
    input  logic                alu_zero,
    input  logic                alu_carry,
    input  logic                alu_negative,
    input  logic                alu_overflow,
    output logic                busy
);

    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
        $error("alu_arbiter: EXEC_CYCLES must be within 1..15");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // cnt counts down to zero, so the operands sit on the ALU for
    // exactly EXEC_CYCLES cycles before the result is sampled.
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       owner;
    logic       last_grant;
    logic       grant;
    logic       req_hs;
    logic       rsp_hs;

    // With both requesters waiting, the one that did not finish last wins;
    // with a single requester waiting, it simply gets the ALU.
    // NOTE: grant gets a default before any branch so no path leaves it
    // unassigned, which keeps this block purely combinational (no latch).
    always_comb begin
        grant = 1'b0;
        if (req0.req_valid && req1.req_valid) begin
            grant = ~last_grant;
        end else if (req1.req_valid) begin
            grant = 1'b1;
        end
    end

    // Ready also requires valid so both readies idle low when nobody asks.
    assign req0.req_ready = (state == IDLE) && req0.req_valid && !grant;
    assign req1.req_ready = (state == IDLE) && req1.req_valid &&  grant;
    assign req_hs         = req0.req_ready || req1.req_ready;

    assign req0.rsp_valid = (state == RESP) && !owner;
    assign req1.rsp_valid = (state == RESP) &&  owner;
    // Only the owner's ready counts; the other requester's ready is ignored.
    assign rsp_hs         = (state == RESP) && (owner ? req1.rsp_ready : req0.rsp_ready);

    assign busy = (state != IDLE);

    // NOTE: every register here uses non-blocking assignment so all state
    // updates on an edge see the pre-edge values of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;   // requester 0 wins the first tie
            alu_a      <= '0;
            alu_b      <= '0;
            alu_aluc   <= '0;
            rsp_r      <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        alu_a    <= grant ? req1.req_a    : req0.req_a;
                        alu_b    <= grant ? req1.req_b    : req0.req_b;
                        alu_aluc <= grant ? req1.req_aluc : req0.req_aluc;
                        owner    <= grant;
                        cnt      <= CNT_INIT;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Flags are passed through exactly as the ALU reports them.
                        rsp_r     <= alu_r;
                        rsp_flags <= {alu_zero, alu_carry, alu_negative, alu_overflow};
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
